// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// Module : sram_arb_pkg
// Brief  : Shared types and widths for the two-requester SRAM arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
// ============================================================================
// Module : sram_arbiter_if
// Brief  : IFU/LSU request-response channels plus the SRAM port bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;

  logic              sram_ren;
  logic              sram_wen;
  logic [MASK_W-1:0] sram_wmask;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_data;

  // Arbiter side
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  sram_data,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata
  );

  // Requester / memory side
  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output sram_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-input round-robin grant; ties go to the requester not served last.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import sram_arb_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_req_ifu,
  input  wire logic i_req_lsu,
  input  wire logic i_advance,
  output req_id_e   o_grant_id,
  output logic      o_grant_valid
);

  req_id_e r_last_grant;

  always_comb begin
    o_grant_valid = i_req_ifu | i_req_lsu;
    if (i_req_ifu && i_req_lsu) begin
      o_grant_id = (r_last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
    end else if (i_req_lsu) begin
      o_grant_id = REQ_LSU;
    end else begin
      o_grant_id = REQ_IFU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= REQ_IFU;
    end else if (i_advance) begin
      r_last_grant <= o_grant_id;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module : sram_arbiter
// Brief  : Shares one combinational SRAM port between IFU and LSU, one access per txn.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input wire logic      clk,
  input wire logic      rst,
  sram_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_wait_init = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  req_id_e           r_id;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;

  logic              r_sram_ren;
  logic              r_sram_wen;
  logic [MASK_W-1:0] r_sram_wmask;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;

  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;
  logic              r_ifu_resp_valid;
  logic              r_lsu_resp_valid;

  req_id_e           w_grant_id;
  logic              w_grant_valid;
  logic              w_accept;
  logic              w_resp_hs;
  logic              w_go_access;
  logic              w_req_wen;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic [MASK_W-1:0] w_req_wmask;
  logic              w_acc_wen;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [MASK_W-1:0] w_acc_wmask;

  rr_arb2 u_rr_arb2 (
    .clk           (clk),
    .rst           (rst),
    .i_req_ifu     (bus.ifu_req_valid),
    .i_req_lsu     (bus.lsu_req_valid),
    .i_advance     (w_accept),
    .o_grant_id    (w_grant_id),
    .o_grant_valid (w_grant_valid)
  );

  // Ready is combinational from the grant, so it must also be masked while reset is held.
  assign w_accept  = (r_state == IDLE) && w_grant_valid && !rst;
  assign w_resp_hs = (r_id == REQ_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready;

  always_comb begin
    w_req_wen   = 1'b0;
    w_req_addr  = bus.ifu_addr;
    w_req_wdata = '0;
    w_req_wmask = '0;
    if (w_grant_id == REQ_LSU) begin
      w_req_wen   = bus.lsu_wen;
      w_req_addr  = bus.lsu_addr;
      w_req_wdata = bus.lsu_wdata;
      w_req_wmask = bus.lsu_wmask;
    end
  end

  // With no wait cycles the strobe fields come straight from the accepted request.
  assign w_go_access = ((r_state == IDLE) && w_accept && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == '0));
  assign w_acc_wen   = (r_state == IDLE) ? w_req_wen   : r_wen;
  assign w_acc_addr  = (r_state == IDLE) ? w_req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? w_req_wdata : r_wdata;
  assign w_acc_wmask = (r_state == IDLE) ? w_req_wmask : r_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_id             <= REQ_IFU;
      r_wen            <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_wmask          <= '0;
      r_sram_ren       <= 1'b0;
      r_sram_wen       <= 1'b0;
      r_sram_wmask     <= '0;
      r_sram_addr      <= '0;
      r_sram_wdata     <= '0;
      r_ifu_rdata      <= '0;
      r_lsu_rdata      <= '0;
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
    end else begin
      r_sram_ren   <= 1'b0;
      r_sram_wen   <= 1'b0;
      r_sram_wmask <= '0;

      if (w_go_access) begin
        r_sram_ren   <= !w_acc_wen;
        r_sram_wen   <= w_acc_wen;
        r_sram_wmask <= w_acc_wen ? w_acc_wmask : '0;
        r_sram_addr  <= w_acc_addr;
        r_sram_wdata <= w_acc_wdata;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant_id;
            r_wen   <= w_req_wen;
            r_addr  <= w_req_addr;
            r_wdata <= w_req_wdata;
            r_wmask <= w_req_wmask;
            r_cnt   <= c_wait_init;
            r_state <= (LATENCY == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACCESS: begin
          r_state <= RESP;
          if (r_id == REQ_IFU) begin
            r_ifu_rdata      <= r_wen ? '0 : bus.sram_data;
            r_ifu_resp_valid <= 1'b1;
          end else begin
            r_lsu_rdata      <= r_wen ? '0 : bus.sram_data;
            r_lsu_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (w_resp_hs) begin
            r_state          <= IDLE;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = w_accept && (w_grant_id == REQ_IFU);
  assign bus.lsu_req_ready  = w_accept && (w_grant_id == REQ_LSU);
  assign bus.ifu_resp_valid = r_ifu_resp_valid;
  assign bus.lsu_resp_valid = r_lsu_resp_valid;
  assign bus.ifu_rdata      = r_ifu_rdata;
  assign bus.lsu_rdata      = r_lsu_rdata;
  assign bus.sram_ren       = r_sram_ren;
  assign bus.sram_wen       = r_sram_wen;
  assign bus.sram_wmask     = r_sram_wmask;
  assign bus.sram_addr      = r_sram_addr;
  assign bus.sram_wdata     = r_sram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module : tb_sram_arbiter
// Brief  : Self-checking bench: vector table, directed corners, randomized vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus drives both instances; sel picks the one being observed.
  logic        sel = 1'b0;
  logic        ifu_v = 0, ifu_rr = 0, lsu_v = 0, lsu_w = 0, lsu_rr = 0;
  logic [31:0] ifu_a = 0, lsu_a = 0, lsu_d = 0;
  logic [7:0]  lsu_m = 0;
  logic        ovr_en = 0;
  logic [31:0] ovr = 0;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return ovr_en ? ovr : hashf(a);
  endfunction

  sram_arbiter_if bus_a();
  sram_arbiter_if bus_b();

  assign bus_a.ifu_req_valid = ifu_v;  assign bus_b.ifu_req_valid = ifu_v;
  assign bus_a.ifu_addr = ifu_a;       assign bus_b.ifu_addr = ifu_a;
  assign bus_a.ifu_resp_ready = ifu_rr; assign bus_b.ifu_resp_ready = ifu_rr;
  assign bus_a.lsu_req_valid = lsu_v;  assign bus_b.lsu_req_valid = lsu_v;
  assign bus_a.lsu_wen = lsu_w;        assign bus_b.lsu_wen = lsu_w;
  assign bus_a.lsu_addr = lsu_a;       assign bus_b.lsu_addr = lsu_a;
  assign bus_a.lsu_wdata = lsu_d;      assign bus_b.lsu_wdata = lsu_d;
  assign bus_a.lsu_wmask = lsu_m;      assign bus_b.lsu_wmask = lsu_m;
  assign bus_a.lsu_resp_ready = lsu_rr; assign bus_b.lsu_resp_ready = lsu_rr;
  assign bus_a.sram_data = exp_data(bus_a.sram_addr);
  assign bus_b.sram_data = exp_data(bus_b.sram_addr);

  sram_arbiter #(.LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sram_arbiter #(.LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  wire        o_ir  = sel ? bus_b.ifu_req_ready  : bus_a.ifu_req_ready;
  wire        o_lr  = sel ? bus_b.lsu_req_ready  : bus_a.lsu_req_ready;
  wire        o_iv  = sel ? bus_b.ifu_resp_valid : bus_a.ifu_resp_valid;
  wire        o_lv  = sel ? bus_b.lsu_resp_valid : bus_a.lsu_resp_valid;
  wire [31:0] o_id  = sel ? bus_b.ifu_rdata      : bus_a.ifu_rdata;
  wire [31:0] o_ld  = sel ? bus_b.lsu_rdata      : bus_a.lsu_rdata;
  wire        o_ren = sel ? bus_b.sram_ren       : bus_a.sram_ren;
  wire        o_wen = sel ? bus_b.sram_wen       : bus_a.sram_wen;
  wire [7:0]  o_msk = sel ? bus_b.sram_wmask     : bus_a.sram_wmask;
  wire [31:0] o_adr = sel ? bus_b.sram_addr      : bus_a.sram_addr;
  wire [31:0] o_wd  = sel ? bus_b.sram_wdata     : bus_a.sram_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-timeline model: a request accepted in cycle T strobes at T+L+1 and
  // responds from T+L+2 until the response handshake; the port is free the cycle after.
  int          L, cyc, m_t;
  bit          m_busy, m_last_lsu, m_id_lsu, m_wen;
  logic [31:0] m_addr, m_wdata, m_saddr, m_swdata, m_ird, m_lrd;
  logic [7:0]  m_wmask;

  task automatic model_reset();
    L = sel ? 0 : 2;
    cyc = 0; m_t = 0; m_busy = 0; m_last_lsu = 0; m_id_lsu = 0; m_wen = 0;
    m_addr = 0; m_wdata = 0; m_wmask = 0; m_saddr = 0; m_swdata = 0; m_ird = 0; m_lrd = 0;
  endtask

  task automatic step_check();
    int d;
    bit gi, gl, strobe, rv;
    gi = 0; gl = 0;
    if (!m_busy) begin
      if (ifu_v && lsu_v) begin gl = !m_last_lsu; gi = m_last_lsu; end
      else begin gi = ifu_v; gl = lsu_v; end
    end
    d = cyc - m_t;
    strobe = m_busy && (d == L + 1);
    rv = m_busy && (d >= L + 2);
    if (strobe) begin m_saddr = m_addr; m_swdata = m_wdata; end
    chk("ifu_req_ready", 32'(o_ir), 32'(gi));
    chk("lsu_req_ready", 32'(o_lr), 32'(gl));
    chk("sram_ren", 32'(o_ren), 32'(strobe && !m_wen));
    chk("sram_wen", 32'(o_wen), 32'(strobe && m_wen));
    chk("sram_wmask", 32'(o_msk), (strobe && m_wen) ? 32'(m_wmask) : 32'd0);
    chk("sram_addr", o_adr, m_saddr);
    chk("sram_wdata", o_wd, m_swdata);
    chk("ifu_resp_valid", 32'(o_iv), 32'(rv && !m_id_lsu));
    chk("lsu_resp_valid", 32'(o_lv), 32'(rv && m_id_lsu));
    chk("ifu_rdata", o_id, m_ird);
    chk("lsu_rdata", o_ld, m_lrd);
    if (strobe) begin
      if (m_id_lsu) m_lrd = m_wen ? 32'd0 : exp_data(m_addr);
      else          m_ird = exp_data(m_addr);
    end
    if (rv && (m_id_lsu ? lsu_rr : ifu_rr)) begin
      m_busy = 0;
    end else if (gi || gl) begin
      m_busy = 1; m_t = cyc; m_id_lsu = gl; m_last_lsu = gl;
      m_wen   = gl ? lsu_w : 1'b0;
      m_addr  = gl ? lsu_a : ifu_a;
      m_wdata = gl ? lsu_d : 32'd0;
      m_wmask = gl ? lsu_m : 8'd0;
    end
    cyc++;
  endtask

  task automatic cyc_apply(input bit iv, input bit lv, input bit lw, input logic [31:0] ia,
                           input logic [31:0] la, input logic [31:0] lwd, input logic [7:0] lm,
                           input bit irr, input bit lrr);
    @(negedge clk);
    ifu_v = iv; lsu_v = lv; lsu_w = lw; ifu_a = ia; lsu_a = la; lsu_d = lwd; lsu_m = lm;
    ifu_rr = irr; lsu_rr = lrr;
    #1;
    step_check();
  endtask

  task automatic idle(input int n, input bit irr, input bit lrr);
    for (int i = 0; i < n; i++) cyc_apply(0, 0, 0, 32'd0, 32'd0, 32'd0, 8'd0, irr, lrr);
  endtask

  // Reset is asserted between edges so only an asynchronous reset clears outputs in time.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1; ifu_v = 1; lsu_v = 1;
    #1;
    chk("rst_ifu_req_ready", 32'(o_ir), 0);
    chk("rst_lsu_req_ready", 32'(o_lr), 0);
    chk("rst_ifu_resp_valid", 32'(o_iv), 0);
    chk("rst_lsu_resp_valid", 32'(o_lv), 0);
    chk("rst_sram_ren", 32'(o_ren), 0);
    chk("rst_sram_wen", 32'(o_wen), 0);
    chk("rst_sram_wmask", 32'(o_msk), 0);
    chk("rst_sram_addr", o_adr, 0);
    chk("rst_sram_wdata", o_wd, 0);
    chk("rst_ifu_rdata", o_id, 0);
    chk("rst_lsu_rdata", o_ld, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; ifu_v = 0; lsu_v = 0;
    model_reset();
  endtask

  typedef struct {
    bit iv;
    bit lv;
    bit lw;
    bit exp_ir;
    bit exp_lr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1, 1, 0, 0, 1};
    vecs[1] = '{1, 1, 1, 1, 0};
    vecs[2] = '{1, 1, 0, 0, 1};
    vecs[3] = '{1, 0, 0, 1, 0};
    vecs[4] = '{1, 0, 0, 1, 0};
    vecs[5] = '{0, 1, 1, 0, 1};
    vecs[6] = '{1, 1, 0, 1, 0};

    do_reset();

    // Grant table from reset: ties alternate starting with LSU
    for (int i = 0; i < 7; i++) begin
      cyc_apply(vecs[i].iv, vecs[i].lv, vecs[i].lw, 32'h40 + 32'(i * 16), 32'h1000 + 32'(i * 4),
                $urandom, 8'hFF, 1, 1);
      chk("tbl_ifu_grant", 32'(o_ir), 32'(vecs[i].exp_ir));
      chk("tbl_lsu_grant", 32'(o_lr), 32'(vecs[i].exp_lr));
      idle(4, 1, 1);
    end

    // IFU read timing with forced SRAM data
    ovr_en = 1; ovr = 32'h1234_5678;
    cyc_apply(1, 0, 0, 32'h0000_0100, 32'd0, 32'd0, 8'd0, 1, 1);
    chk("ifu_rd_ready_T", 32'(o_ir), 1);
    for (int k = 1; k <= 4; k++) begin
      idle(1, 1, 1);
      chk("ifu_rd_ren", 32'(o_ren), 32'(k == 3));
      chk("ifu_rd_resp_valid", 32'(o_iv), 32'(k == 4));
    end
    chk("ifu_rd_rdata", o_id, 32'h1234_5678);
    ovr_en = 0;

    // LSU masked write
    cyc_apply(0, 1, 1, 32'd0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 1, 1);
    chk("lsu_wr_ready_T", 32'(o_lr), 1);
    for (int k = 1; k <= 4; k++) begin
      idle(1, 1, 1);
      chk("lsu_wr_ren", 32'(o_ren), 0);
      chk("lsu_wr_wen", 32'(o_wen), 32'(k == 3));
      if (k == 3) begin
        chk("lsu_wr_wmask", 32'(o_msk), 32'h0F);
        chk("lsu_wr_addr", o_adr, 32'h8000_0010);
        chk("lsu_wr_wdata", o_wd, 32'hDEAD_BEEF);
      end
    end
    chk("lsu_wr_resp_valid", 32'(o_lv), 1);
    chk("lsu_wr_rdata", o_ld, 0);

    // Response backpressure with both requesters pushing
    cyc_apply(0, 1, 0, 32'd0, 32'h0000_0A00, 32'd0, 8'd0, 0, 0);
    idle(3, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc_apply(1, 1, 0, 32'h300, 32'h304, 32'd0, 8'd0, 0, 0);
      chk("bp_lsu_resp_valid", 32'(o_lv), 1);
      chk("bp_lsu_rdata", o_ld, hashf(32'h0000_0A00));
      chk("bp_no_strobe", 32'(o_ren | o_wen), 0);
      chk("bp_no_ready", 32'(o_ir | o_lr), 0);
    end
    cyc_apply(1, 1, 0, 32'h300, 32'h304, 32'd0, 8'd0, 0, 1);
    chk("bp_hs_no_accept", 32'(o_ir | o_lr), 0);
    cyc_apply(1, 1, 0, 32'h300, 32'h304, 32'd0, 8'd0, 1, 1);
    chk("bp_next_grant_ifu", 32'(o_ir), 1);
    idle(4, 1, 1);

    // Reset while in WAIT drops the request
    cyc_apply(1, 0, 0, 32'h0000_0200, 32'd0, 32'd0, 8'd0, 1, 1);
    do_reset();
    idle(6, 1, 1);
    cyc_apply(1, 0, 0, 32'h0000_0300, 32'd0, 32'd0, 8'd0, 1, 1);
    idle(4, 1, 1);
    chk("post_rst_ifu_rdata", o_id, hashf(32'h0000_0300));

    // Randomized traffic, LATENCY=2
    for (int i = 0; i < 400; i++) begin
      cyc_apply($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom, $urandom, $urandom, 8'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    // LATENCY=0 instance
    sel = 1;
    do_reset();
    cyc_apply(0, 1, 0, 32'd0, 32'h2000_0004, 32'd0, 8'd0, 1, 1);
    chk("l0_ready_T", 32'(o_lr), 1);
    chk("l0_ren_T", 32'(o_ren), 0);
    idle(1, 1, 1);
    chk("l0_ren_T1", 32'(o_ren), 1);
    chk("l0_resp_T1", 32'(o_lv), 0);
    idle(1, 1, 1);
    chk("l0_resp_T2", 32'(o_lv), 1);
    chk("l0_rdata", o_ld, hashf(32'h2000_0004));
    for (int i = 0; i < 300; i++) begin
      cyc_apply($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom, $urandom, $urandom, 8'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single combinational `sram` (DPI-C pmem) port between two requesters: IFU (read-only) and LSU (read/write).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A configurable wait count models memory latency.
- The arbiter guarantees `sram_ren`/`sram_wen` are each asserted for exactly one cycle per accepted transaction, so each pmem access happens once.

Parameters:
- LATENCY, 2, number of WAIT cycles between request acceptance and the SRAM access cycle; 0 skips WAIT; legal range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  32  IFU read address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU accepts response.
- ifu_rdata  out  32  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_addr  in  32  LSU address.
- lsu_wdata  in  32  LSU write data.
- lsu_wmask  in  8  LSU byte write mask.
- lsu_resp_valid  out  1  LSU response (read data or write ack).
- lsu_resp_ready  in  1  LSU accepts response.
- lsu_rdata  out  32  LSU read data; 0 for write acks.
- sram_ren  out  1  to sram ren.
- sram_wen  out  1  to sram wen.
- sram_wmask  out  8  to sram wmask.
- sram_addr  out  32  to sram addr.
- sram_wdata  out  32  to sram wdata.
- sram_data  in  32  from sram data (combinational).

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Reset state is IDLE.
- Reset (async, any state, including mid-transaction):
  - Outputs: all *_ready, *_resp_valid, sram_ren, sram_wen = 0; sram_wmask, sram_addr, sram_wdata = 0; rdata registers = 0; wait counter = 0.
  - Round-robin pointer last_grant = IFU.
  - An in-flight transaction is dropped with no SRAM access and no response.
- IDLE:
  - Grant is combinational. If exactly one req_valid is high, grant it. If both are high, grant the requester not equal to last_grant.
  - The granted requester's req_ready = 1 in the same cycle; the other's req_ready = 0. req_ready is 0 in every state except IDLE.
  - On handshake, latch id, addr, wdata, wmask and wen (IFU forces wen = 0, wmask = 0). Update last_grant.
  - Next state is WAIT with counter = LATENCY−1, or ACCESS directly if LATENCY = 0.
- WAIT: decrement the counter each cycle; at 0 go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive sram_addr and sram_wdata from the latched values.
  - sram_ren = !wen_l; sram_wen = wen_l; sram_wmask = wen_l ? wmask_l : 0.
  - Capture sram_data into the selected requester's rdata register on reads; capture 0 on writes.
  - Next state is RESP.
- RESP:
  - Only the selected requester's resp_valid = 1; rdata is held stable.
  - On resp_ready, go to IDLE and deassert resp_valid the next cycle.
  - No new request is accepted in the cycle resp_ready handshakes; arbitration resumes in the following IDLE cycle.
- Outside ACCESS: sram_ren = 0, sram_wen = 0, sram_wmask = 0. sram_addr and sram_wdata hold their last values.
- Latency: from the request handshake cycle T, the SRAM strobe occurs at T+LATENCY+1 and resp_valid first rises at T+LATENCY+2. Throughput is at most one transaction per LATENCY+3 cycles.
- Address and data pass through unchanged; there are no alignment checks.
- Back-to-back requests from the same requester with the other idle are granted every time; round-robin applies only on ties.

Decomposition:
- Package `sram_arb_pkg`:
  - state enum {IDLE, WAIT, ACCESS, RESP}.
  - requester id enum {REQ_IFU, REQ_LSU}.
  - localparam widths ADDR_W = 32, DATA_W = 32, MASK_W = 8.
- One sub-module `rr_arb2`: two-input round-robin grant with a last_grant register and an advance strobe. The rest stays in `sram_arbiter`.

Test Plan:
- IFU read only, LATENCY = 2, sram_data = 32'h1234_5678 at the access cycle → ifu_req_ready at T; sram_ren high only at T+3; ifu_resp_valid at T+4; ifu_rdata = 32'h1234_5678.
- LSU write addr = 32'h8000_0010, wdata = 32'hDEAD_BEEF, wmask = 8'h0F → single-cycle sram_wen with wmask 8'h0F; sram_ren = 0 throughout; lsu_resp_valid with lsu_rdata = 0.
- Both requesting simultaneously from reset, three times in succession → grants LSU, IFU, LSU; the non-granted req_ready stays 0.
- Response backpressure: hold lsu_resp_ready = 0 for 5 cycles → lsu_resp_valid and lsu_rdata stable; no SRAM strobe; req_ready = 0 for both.
- LATENCY = 0 → strobe at T+1, resp_valid at T+2.
- Assert rst during WAIT → all outputs 0 immediately (asynchronous); no sram_ren or sram_wen ever pulses for the dropped request; after release, a new IFU request completes normally.
